relu_norm_lanes: RTL and testbench
==================================

// Module: relu_norm_lanes
// PURPOSE
//  Parametrised successor to the layer post-MAC stage: bias add, ReLU, mean-only normalisation.
//  Processes LANES neurons per beat over wide raw/bias/output memories; NUM_NEURONS = BEATS*LANES.
//  Sits between mac_unit (start = its done) and the activation buffer.
//  Also exports the layer mean. Optionally exports Forward-Forward goodness.
// PARAMETERS
//  NUM_NEURONS  256  neurons per layer; power of two; multiple of LANES
//  LANES        4    neurons per beat; power of two, 1..NUM_NEURONS
//  DATA_WIDTH   32   signed fixed-point word
//  FRAC_BITS    16   fraction bits (Q16.16 default)
//  BEATS = NUM_NEURONS/LANES; ADDR_W = max(1,$clog2(BEATS)); LOG2N = $clog2(NUM_NEURONS)  (localparams)
// PORTS
//  clk            in   1                 clock
//  rst_n          in   1                 async active-low reset
//  start          in   1                 one-cycle pulse; sampled in IDLE only
//  busy           out  1                 high in any state except IDLE
//  done           out  1                 one-cycle pulse at completion
//  buf_clear      out  1                 one-cycle pulse, first cycle after start is accepted
//  raw_addr       out  ADDR_W            beat address of raw MAC results
//  raw_en         out  1                 raw read enable
//  raw_rdata      in   LANES*DATA_WIDTH  lane k = bits [k*DW +: DW]; valid cycle after raw_en
//  bias_addr      out  ADDR_W            beat address of bias memory
//  bias_en        out  1                 bias read enable, same timing as raw_en
//  bias_rdata     in   LANES*DATA_WIDTH  lane-packed like raw_rdata
//  out_addr       out  ADDR_W            activation buffer beat address
//  out_we         out  1                 activation buffer write enable
//  out_wdata      out  LANES*DATA_WIDTH  normalised values, lane-packed
//  mean_out       out  DATA_WIDTH        layer mean; updated in MEAN; held until next MEAN
//  goodness_out   out  2*DATA_WIDTH      [RELU_NORM_GOODNESS_EN only] sum of squares
// BEHAVIOUR
//  Reset: state IDLE. All outputs, addresses and wdata are 0. Accumulators, post-ReLU store and mean are 0.
//  Reset asserted mid-operation aborts immediately. No done pulse. The next start runs a full layer.
//  FSM: IDLE -> LOAD -> MEAN -> NORM -> DONE -> IDLE.
//   IDLE: on start -> LOAD, pulse buf_clear, clear sum/beat counters.
//   LOAD (BEATS+1 cycles):
//    - Cycle i<BEATS drives raw_en=bias_en=1 with addr=i.
//    - Cycle i+1 captures that beat's rdata (read pipeline, one beat per cycle).
//    - Per lane: s = raw+bias at DW+1 bits, saturated to [0x80000000,0x7FFFFFFF].
//    - r = (s>0)?s:0, stored in internal post_relu[i*LANES+k].
//    - Sum of all LANES r values added to sum_acc (DW+LOG2N+1 bits, signed).
//   MEAN (1 cycle): mean_out <= sum_acc >>> LOG2N (floor).
//   NORM (BEATS cycles): cycle j drives out_we=1, out_addr=j.
//    - Lane k of out_wdata = sat(post_relu[j*LANES+k] - mean), computed at DW+1 bits.
//   DONE (1 cycle): done=1, then IDLE.
//  Latency: done is high in cycle 2*BEATS+2, counting the first LOAD cycle as cycle 0.
//  Pulses (done, buf_clear, en, we) are registered and default low every cycle.
//  start while busy is ignored. start in the DONE cycle is ignored.
//  BEATS=1 is legal: addresses stay 0.
//  raw/bias rdata is only sampled in the capture cycle. Other cycles are don't-care.
// CONFIGURATION
//  RELU_NORM_GOODNESS_EN defined:
//   - During LOAD, each lane r is squared; (r*r)>>>FRAC_BITS (2*DW bits) is accumulated.
//   - The accumulator saturates at 2^(2*DW-1)-1.
//   - goodness_out is registered in MEAN and held until the next MEAN; reset 0.
//  RELU_NORM_GOODNESS_EN undefined: goodness_out port absent; no multipliers synthesised.
// TESTING (NUM_NEURONS=8, LANES=4, Q16.16 unless noted)
//  Ramp: raw={0..7}.0, bias=0.
//   -> mean_out=0x00038000; out=-3.5..+3.5 (0xFFFC8000..0x00038000).
//   -> writes at addr 0,1; done at cycle 6.
//  All negative: raw=-2.0, bias=+1.0 -> mean_out=0; every out lane 0; goodness_out=0.
//  Saturation: raw lane0=0x7FFFFFFF, bias lane0=0x00010000, rest 0.
//   -> post_relu0=0x7FFFFFFF; mean_out=0x0FFFFFFF; out lane0=0x70000000.
//  Goodness (macro on): all raw=2.0, bias=0 -> goodness_out=0x0000000000200000 (32.0); mean_out=0x00020000.
//  start pulsed during NORM -> ignored; exactly one done; buf_clear pulsed once.
//  rst_n low during LOAD -> outputs 0, no done; next start with ramp data reproduces the ramp result.

Source files
------------

// File: rtl/relu_norm_lanes.sv
// relu_norm_lanes: bias add, ReLU and mean-only normalisation over LANES
// neurons per beat. Reads raw MAC results and biases beat by beat, keeps the
// rectified values internally, derives the layer mean, then writes the
// mean-subtracted values to the activation buffer.
// Optional feature macro: RELU_NORM_GOODNESS_EN adds the goodness_out port
// (saturating sum of (r*r)>>>FRAC_BITS over all rectified values).
module relu_norm_lanes #(
  parameter int NUM_NEURONS = 256,
  parameter int LANES       = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int FRAC_BITS   = 16,
  localparam int BEATS      = NUM_NEURONS / LANES,
  localparam int ADDR_W     = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int LOG2N      = $clog2(NUM_NEURONS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        buf_clear,
  output logic [ADDR_W-1:0]           raw_addr,
  output logic                        raw_en,
  input  logic [LANES*DATA_WIDTH-1:0] raw_rdata,
  output logic [ADDR_W-1:0]           bias_addr,
  output logic                        bias_en,
  input  logic [LANES*DATA_WIDTH-1:0] bias_rdata,
  output logic [ADDR_W-1:0]           out_addr,
  output logic                        out_we,
  output logic [LANES*DATA_WIDTH-1:0] out_wdata,
  output logic [DATA_WIDTH-1:0]       mean_out
`ifdef RELU_NORM_GOODNESS_EN
  ,
  output logic [2*DATA_WIDTH-1:0]     goodness_out
`endif
);

  localparam int DW = DATA_WIDTH;
  localparam int SW = DW + LOG2N + 1;
  localparam int CW = ADDR_W + 1;

  if (FRAC_BITS < 0 || FRAC_BITS >= DATA_WIDTH || (NUM_NEURONS % LANES) != 0) begin : g_param_check
    $error("relu_norm_lanes: illegal parameter combination");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MEAN, S_NORM, S_DONE} state_t;

  // Clamp a DW+1 bit signed value into the DW bit signed range.
  function automatic logic signed [DW-1:0] sat_dw(input logic signed [DW:0] x);
    if (x[DW] != x[DW-1])
      sat_dw = x[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      sat_dw = x[DW-1:0];
  endfunction

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                raw_en_d, out_we_d, buf_clear_d, done_d, clr_d;
  logic [ADDR_W-1:0]   raw_addr_d, out_addr_d;

  logic                vld_p1;
  logic [ADDR_W-1:0]   beat_p1;
  logic [LANES*DW-1:0] relu_p1;
  logic signed [SW-1:0] beat_sum_p1;
  logic signed [DW-1:0] lane_s, lane_r, norm_r;
  logic signed [SW-1:0] sum_acc;
  logic signed [DW-1:0] mean_c;
  logic [LANES*DW-1:0] post_relu [2**ADDR_W];
  logic [LANES*DW-1:0] norm_row, norm_d;

  assign busy      = (state_q != S_IDLE);
  assign bias_en   = raw_en;
  assign bias_addr = raw_addr;
  // Rectified values are never negative, so truncating the shifted sum is exact.
  assign mean_c    = sum_acc[LOG2N +: DW];

  // Next-state and next registered control outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cnt_inc     = cnt_q + 1'b1;
    raw_en_d    = 1'b0;
    raw_addr_d  = raw_addr;
    out_we_d    = 1'b0;
    out_addr_d  = out_addr;
    buf_clear_d = 1'b0;
    done_d      = 1'b0;
    clr_d       = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d     = S_LOAD;
        cnt_d       = '0;
        raw_en_d    = 1'b1;
        raw_addr_d  = '0;
        buf_clear_d = 1'b1;
        clr_d       = 1'b1;
      end
      S_LOAD: if (cnt_q == CW'(BEATS)) begin
        state_d = S_MEAN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_inc;
        if (cnt_inc < CW'(BEATS)) begin
          raw_en_d   = 1'b1;
          raw_addr_d = cnt_inc[ADDR_W-1:0];
        end
      end
      S_MEAN: begin
        state_d    = S_NORM;
        cnt_d      = '0;
        out_we_d   = 1'b1;
        out_addr_d = '0;
      end
      S_NORM: if (cnt_q == CW'(BEATS - 1)) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end else begin
        cnt_d      = cnt_inc;
        out_we_d   = 1'b1;
        out_addr_d = cnt_inc[ADDR_W-1:0];
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register and registered control pulses/addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      raw_en    <= 1'b0;
      raw_addr  <= '0;
      out_we    <= 1'b0;
      out_addr  <= '0;
      buf_clear <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      raw_en    <= raw_en_d;
      raw_addr  <= raw_addr_d;
      out_we    <= out_we_d;
      out_addr  <= out_addr_d;
      buf_clear <= buf_clear_d;
      done      <= done_d;
    end
  end

  // ---- p1: read data returned; bias add, saturate, rectify, reduce ----
  // Per-lane bias add with saturation, ReLU and beat partial sum.
  always_comb begin
    relu_p1     = '0;
    beat_sum_p1 = '0;
    lane_s      = '0;
    lane_r      = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_s = sat_dw({raw_rdata[k*DW+DW-1], raw_rdata[k*DW +: DW]} +
                      {bias_rdata[k*DW+DW-1], bias_rdata[k*DW +: DW]});
      lane_r = (lane_s > 0) ? lane_s : '0;
      relu_p1[k*DW +: DW] = lane_r;
      beat_sum_p1 = beat_sum_p1 + SW'(lane_r);
    end
  end

  // ---- norm: subtract the layer mean from one stored beat ----
  // Mean subtraction for the beat about to be written.
  always_comb begin
    norm_row = post_relu[out_addr_d];
    norm_d   = '0;
    norm_r   = '0;
    for (int k = 0; k < LANES; k++) begin
      norm_r = norm_row[k*DW +: DW];
      norm_d[k*DW +: DW] = sat_dw({norm_r[DW-1], norm_r} - {mean_c[DW-1], mean_c});
    end
  end

  // Capture pipeline, accumulator, post-ReLU store, mean and write data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      beat_p1   <= '0;
      sum_acc   <= '0;
      mean_out  <= '0;
      out_wdata <= '0;
      for (int i = 0; i < 2**ADDR_W; i++) post_relu[i] <= '0;
    end else begin
      vld_p1  <= raw_en;
      beat_p1 <= raw_addr;
      if (clr_d)       sum_acc <= '0;
      else if (vld_p1) sum_acc <= sum_acc + beat_sum_p1;
      if (vld_p1) post_relu[beat_p1] <= relu_p1;
      if (state_q == S_MEAN) mean_out <= mean_c;
      if (out_we_d) out_wdata <= norm_d;
    end
  end

`ifdef RELU_NORM_GOODNESS_EN
  localparam int GW  = 2 * DW;
  localparam int GAW = GW + $clog2(LANES) + 2;

  logic signed [GW-1:0]  lane_w, lane_sq;
  logic signed [GAW-1:0] sq_sum_p1, good_tot;
  logic signed [GW-1:0]  good_acc, good_nxt;

  // Clamp the running goodness at the largest positive 2*DW value.
  function automatic logic signed [GW-1:0] sat_good(input logic signed [GAW-1:0] x);
    if (|x[GAW-1:GW-1]) sat_good = {1'b0, {(GW-1){1'b1}}};
    else                sat_good = x[GW-1:0];
  endfunction

  // Per-lane square in fixed point and beat sum of squares.
  always_comb begin
    sq_sum_p1 = '0;
    lane_w    = '0;
    lane_sq   = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_w    = GW'($signed(relu_p1[k*DW +: DW]));
      lane_sq   = (lane_w * lane_w) >>> FRAC_BITS;
      sq_sum_p1 = sq_sum_p1 + GAW'(lane_sq);
    end
    good_tot = GAW'(good_acc) + sq_sum_p1;
    good_nxt = sat_good(good_tot);
  end

  // Goodness accumulator and its exported copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_acc     <= '0;
      goodness_out <= '0;
    end else begin
      if (clr_d)       good_acc <= '0;
      else if (vld_p1) good_acc <= good_nxt;
      if (state_q == S_MEAN) goodness_out <= good_acc;
    end
  end
`endif

endmodule

// File: tb/tb_relu_norm_lanes.sv
// Self-checking bench for relu_norm_lanes (8 neurons, 4 lanes, Q16.16).
module tb_relu_norm_lanes;
  localparam int NN = 8;
  localparam int LN = 4;
  localparam int DW = 32;
  localparam int FB = 16;
  localparam int BT = NN / LN;
  localparam int AW = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy, done, buf_clear;
  logic [AW-1:0] raw_addr, bias_addr, out_addr;
  logic          raw_en, bias_en, out_we;
  logic [LN*DW-1:0] raw_rdata, bias_rdata, out_wdata;
  logic [DW-1:0] mean_out;
`ifdef RELU_NORM_GOODNESS_EN
  logic [2*DW-1:0] goodness_out;
`endif

  relu_norm_lanes #(.NUM_NEURONS(NN), .LANES(LN), .DATA_WIDTH(DW), .FRAC_BITS(FB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .buf_clear(buf_clear), .raw_addr(raw_addr), .raw_en(raw_en), .raw_rdata(raw_rdata),
    .bias_addr(bias_addr), .bias_en(bias_en), .bias_rdata(bias_rdata),
    .out_addr(out_addr), .out_we(out_we), .out_wdata(out_wdata), .mean_out(mean_out)
`ifdef RELU_NORM_GOODNESS_EN
    , .goodness_out(goodness_out)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic signed [DW-1:0] raw_n  [NN];
  logic signed [DW-1:0] bias_n [NN];
  logic [DW-1:0] exp_out [NN];
  logic [DW-1:0] got_out [NN];
  logic [DW-1:0] exp_mean;
  logic [63:0]   exp_good;

  int mon_cyc = 0;
  bit mon_on  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] clamp32(input longint v);
    if (v > 64'sd2147483647)  return 32'h7FFFFFFF;
    if (v < -64'sd2147483648) return 32'h80000000;
    return v[31:0];
  endfunction

  // Reference: whole-layer arithmetic on plain integers.
  task automatic model();
    longint s, sum, m, g;
    longint r [NN];
    sum = 0;
    g   = 0;
    for (int n = 0; n < NN; n++) begin
      s    = longint'(raw_n[n]) + longint'(bias_n[n]);
      r[n] = longint'($signed(clamp32(s)));
      if (r[n] < 0) r[n] = 0;
      sum += r[n];
      g   += (r[n] * r[n]) >>> FB;
    end
    m = sum / NN;
    exp_mean = m[31:0];
    for (int n = 0; n < NN; n++) exp_out[n] = clamp32(r[n] - m);
    exp_good = g;
  endtask

  // Memory model: one-cycle read latency, garbage when not reading.
  initial begin
    logic          pend_r, pend_b;
    logic [AW-1:0] pa_r, pa_b;
    pend_r = 1'b0; pend_b = 1'b0; pa_r = '0; pa_b = '0;
    raw_rdata = '0; bias_rdata = '0;
    forever begin
      @(posedge clk); #1;
      raw_rdata  = {$urandom(), $urandom(), $urandom(), $urandom()};
      bias_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (pend_r) for (int k = 0; k < LN; k++) raw_rdata[k*DW +: DW]  = raw_n[int'(pa_r)*LN + k];
      if (pend_b) for (int k = 0; k < LN; k++) bias_rdata[k*DW +: DW] = bias_n[int'(pa_b)*LN + k];
      pend_r = raw_en;  pa_r = raw_addr;
      pend_b = bias_en; pa_b = bias_addr;
    end
  end

  // Per-cycle compare against the expected schedule and model results.
  initial begin
    int  b;
    bit  we_exp;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        chk("busy", busy, mon_cyc <= 2*BT+2);
        chk("buf_clear", buf_clear, mon_cyc == 0);
        chk("raw_en", raw_en, mon_cyc < BT);
        chk("bias_en", bias_en, mon_cyc < BT);
        if (mon_cyc < BT) begin
          chk("raw_addr", raw_addr, mon_cyc);
          chk("bias_addr", bias_addr, mon_cyc);
        end
        we_exp = (mon_cyc >= BT+2) && (mon_cyc <= 2*BT+1);
        chk("out_we", out_we, we_exp);
        if (we_exp) begin
          b = mon_cyc - BT - 2;
          chk("out_addr", out_addr, b);
          for (int k = 0; k < LN; k++) begin
            got_out[b*LN+k] = out_wdata[k*DW +: DW];
            chk($sformatf("out_wdata[%0d]", b*LN+k), out_wdata[k*DW +: DW], exp_out[b*LN+k]);
          end
        end
        chk("done", done, mon_cyc == 2*BT+2);
        if (mon_cyc >= BT+2) begin
          chk("mean_out", mean_out, exp_mean);
`ifdef RELU_NORM_GOODNESS_EN
          chk("goodness_out", goodness_out, exp_good);
`endif
        end
        if (mon_cyc == 2*BT+3) mon_on = 1'b0;
        mon_cyc++;
      end
    end
  end

  task automatic run_layer(input int ia, input int ib);
    model();
    for (int n = 0; n < NN; n++) got_out[n] = 'x;
    start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    mon_cyc = 0;
    mon_on  = 1'b1;
    for (int c = 0; c < 64 && mon_on; c++) begin
      start = (c == ia) || (c == ib);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("run_complete", mon_on, 0);
    mon_on = 1'b0;
  endtask

  task automatic set_ramp();
    for (int n = 0; n < NN; n++) begin raw_n[n] = n << 16; bias_n[n] = 0; end
  endtask

  task automatic set_const(input logic [DW-1:0] rv, input logic [DW-1:0] bv);
    for (int n = 0; n < NN; n++) begin raw_n[n] = rv; bias_n[n] = bv; end
  endtask

  task automatic set_rand();
    for (int n = 0; n < NN; n++) begin
      raw_n[n]  = $urandom;
      bias_n[n] = $urandom;
      if ($urandom_range(0, 1) == 1) raw_n[n]  = raw_n[n]  >>> $urandom_range(4, 20);
      if ($urandom_range(0, 1) == 1) bias_n[n] = bias_n[n] >>> $urandom_range(4, 20);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    set_ramp();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_buf_clear", buf_clear, 0);
    chk("rst_raw_en", raw_en, 0);
    chk("rst_out_we", out_we, 0);
    chk("rst_addrs", {raw_addr, bias_addr, out_addr}, 0);
    chk("rst_wdata_lo", out_wdata[63:0], 0);
    chk("rst_wdata_hi", out_wdata[127:64], 0);
    chk("rst_mean", mean_out, 0);
`ifdef RELU_NORM_GOODNESS_EN
    chk("rst_goodness", goodness_out, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    set_ramp();
    run_layer(-1, -1);
    chk("ramp_mean", mean_out, 32'h00038000);
    chk("ramp_out0", got_out[0], 32'hFFFC8000);
    chk("ramp_out7", got_out[7], 32'h00038000);

    set_const(32'hFFFE0000, 32'h00010000);
    run_layer(-1, -1);
    chk("neg_mean", mean_out, 32'h0);
    chk("neg_out3", got_out[3], 32'h0);
`ifdef RELU_NORM_GOODNESS_EN
    chk("neg_goodness", goodness_out, 64'h0);
`endif

    set_const(32'h0, 32'h0);
    raw_n[0]  = 32'h7FFFFFFF;
    bias_n[0] = 32'h00010000;
    run_layer(-1, -1);
    chk("sat_mean", mean_out, 32'h0FFFFFFF);
    chk("sat_out0", got_out[0], 32'h70000000);
    chk("sat_out1", got_out[1], 32'hF0000001);

    set_const(32'h00020000, 32'h0);
    run_layer(-1, -1);
    chk("two_mean", mean_out, 32'h00020000);
    chk("two_out5", got_out[5], 32'h0);
`ifdef RELU_NORM_GOODNESS_EN
    chk("two_goodness", goodness_out, 64'h0000000000200000);
`endif

    // start during NORM and during DONE must both be ignored
    set_ramp();
    run_layer(BT+2, 2*BT+2);

    // reset in the middle of LOAD aborts without a done pulse
    set_rand();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_raw_en", raw_en, 0);
    chk("abort_out_we", out_we, 0);
    chk("abort_mean", mean_out, 0);
    chk("abort_wdata", out_wdata[63:0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      chk("abort_idle", busy, 0);
    end
    @(posedge clk); #1;
    set_ramp();
    run_layer(-1, -1);
    chk("ramp2_mean", mean_out, 32'h00038000);
    chk("ramp2_out1", got_out[1], 32'hFFFD8000);

    for (int t = 0; t < 30; t++) begin
      set_rand();
      run_layer($urandom_range(1, 2*BT+2), -1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
